// File: rtl/apb_slave_mem.sv
// APB slave with a 16 x 32-bit register memory and WAIT_CYCLES access-phase wait states.
// Optional PSLVERR output and address-error checking, enabled by defining APB_SLV_PSLVERR_EN.
module apb_slave_mem #(
  parameter int unsigned SEL_IDX     = 0,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        CLK,
  input  logic        PRESETn,
  input  logic [3:0]  PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY
`ifdef APB_SLV_PSLVERR_EN
  ,
  output logic        PSLVERR
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_READY
  } state_t;

  localparam logic [2:0] CNT_INIT = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  state_t      state_q;
  state_t      state_d;
  logic [2:0]  cnt_q;
  logic [2:0]  cnt_d;
  logic [31:0] mem [16];
  logic        sel;
  logic        setup;
  logic        access;
  logic [3:0]  idx;
  logic        err_c;
  logic        err_q;
  logic        wr_en;
  logic        unused_bits;

  assign sel    = PSEL[SEL_IDX[1:0]];
  assign setup  = sel & ~PENABLE;
  assign access = sel & PENABLE;
  assign idx    = PADDR[5:2];

`ifdef APB_SLV_PSLVERR_EN
  assign err_c   = (|PADDR[1:0]) | (|PADDR[11:6]);
  assign PSLVERR = err_q;
`else
  assign err_c   = 1'b0;
`endif

  assign unused_bits = ^{PADDR[31:12], PADDR[11:6], PADDR[1:0], PSEL};

  // Write commits in the PREADY cycle; an errored transfer never touches memory.
  assign wr_en = access & PREADY & PWRITE & ~err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_READY: begin
        if (setup) begin
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = ST_READY;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (!access) begin
          state_d = ST_IDLE;
        end else if (cnt_q == 3'd0) begin
          state_d = ST_READY;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // PREADY/PRDATA/PSLVERR are registered from the next state so they line up with ST_READY.
  always_ff @(posedge CLK) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      PREADY  <= 1'b0;
      PRDATA  <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < 16; i++) begin
        mem[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      PREADY  <= (state_d == ST_READY);
      err_q   <= (state_d == ST_READY) & err_c;
      PRDATA  <= ((state_d == ST_READY) && !err_c) ? mem[idx] : '0;
      if (wr_en) begin
        mem[idx] <= PWDATA;
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_mem.sv
// Scoreboard bench for apb_slave_mem: three instances share one APB bus on PSEL bits 0/2/3
// with WAIT_CYCLES 0/2/3; a negedge monitor checks every PREADY against queued expectations.
module tb_apb_slave_mem;

  logic        CLK = 1'b0;
  logic        PRESETn;
  logic [3:0]  PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] rd0, rd2, rd3;
  logic        rdy0, rdy2, rdy3;
`ifdef APB_SLV_PSLVERR_EN
  logic        er0, er2, er3;
`endif

  always #5 CLK = ~CLK;

  apb_slave_mem #(.SEL_IDX(0), .WAIT_CYCLES(0)) dut0 (
    .CLK(CLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(rd0), .PREADY(rdy0)
`ifdef APB_SLV_PSLVERR_EN
    , .PSLVERR(er0)
`endif
  );

  apb_slave_mem #(.SEL_IDX(2), .WAIT_CYCLES(2)) dut2 (
    .CLK(CLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(rd2), .PREADY(rdy2)
`ifdef APB_SLV_PSLVERR_EN
    , .PSLVERR(er2)
`endif
  );

  apb_slave_mem #(.SEL_IDX(3), .WAIT_CYCLES(3)) dut3 (
    .CLK(CLK), .PRESETn(PRESETn), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(rd3), .PREADY(rdy3)
`ifdef APB_SLV_PSLVERR_EN
    , .PSLVERR(er3)
`endif
  );

  typedef struct {
    int unsigned k;
    logic [31:0] data;
    logic        chk_data;
    logic        err;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic        mon_en = 1'b0;
  int unsigned acc [4] = '{default: 0};

  function automatic logic get_rdy(int unsigned k);
    case (k)
      0:       return rdy0;
      2:       return rdy2;
      default: return rdy3;
    endcase
  endfunction

  function automatic logic [31:0] get_rd(int unsigned k);
    case (k)
      0:       return rd0;
      2:       return rd2;
      default: return rd3;
    endcase
  endfunction

`ifdef APB_SLV_PSLVERR_EN
  function automatic logic get_err(int unsigned k);
    case (k)
      0:       return er0;
      2:       return er2;
      default: return er3;
    endcase
  endfunction
`endif

  function automatic int unsigned wc(int unsigned k);
    case (k)
      0:       return 0;
      2:       return 2;
      default: return 3;
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: counts access cycles per slave and pops one expectation per PREADY pulse.
  always @(negedge CLK) begin
    if (mon_en && PRESETn === 1'b1) begin
      for (int unsigned k = 0; k < 4; k++) begin
        if (k == 1) continue;
        if (PSEL[k] && PENABLE) acc[k]++;
        else acc[k] = 0;
        if (get_rdy(k)) begin
          if (sb.size() == 0) begin
            check($sformatf("unexpected_pready_s%0d", k), 32'(get_rdy(k)), 32'd0);
          end else begin
            exp_t e;
            e = sb.pop_front();
            check("pready_slave", 32'(k), 32'(e.k));
            check($sformatf("pready_latency_s%0d", k), 32'(acc[k]), 32'(e.lat));
            if (e.chk_data) check($sformatf("prdata_s%0d", k), get_rd(k), e.data);
`ifdef APB_SLV_PSLVERR_EN
            check($sformatf("pslverr_s%0d", k), 32'(get_err(k)), 32'(e.err));
`endif
          end
        end else begin
          check($sformatf("idle_prdata_s%0d", k), get_rd(k), 32'd0);
        end
      end
    end
  end

  task automatic idle();
    PSEL    = '0;
    PENABLE = 1'b0;
    @(posedge CLK);
    #1;
  endtask

  // abort_n > 0: drop the strobe after that many access cycles and expect no response.
  task automatic xfer(input int unsigned k, input logic wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [31:0] exp_rd,
                      input logic exp_err, input int unsigned abort_n);
    exp_t e;
    int unsigned n;
    logic done;
    if (abort_n == 0) begin
      e.k        = k;
      e.data     = exp_rd;
      e.chk_data = !wr || exp_err;
      e.err      = exp_err;
      e.lat      = wc(k) + 1;
      sb.push_back(e);
    end
    PSEL    = 4'(1 << k);
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = addr;
    PWDATA  = data;
    @(posedge CLK);
    #1;
    PENABLE = 1'b1;
    if (abort_n > 0) begin
      repeat (abort_n) @(posedge CLK);
      #1;
      PSEL    = '0;
      PENABLE = 1'b0;
    end else begin
      n    = 0;
      done = 1'b0;
      while (!done && n < 20) begin
        @(negedge CLK);
        if (get_rdy(k)) done = 1'b1;
        n++;
      end
      if (!done) check($sformatf("xfer_timeout_s%0d", k), 32'(get_rdy(k)), 32'd1);
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    PRESETn = 1'b0;
    PSEL    = '0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
    repeat (3) @(posedge CLK);
    #1;
    check("reset_pready0", 32'(rdy0), 32'd0);
    check("reset_prdata0", rd0, 32'd0);
    check("reset_pready2", 32'(rdy2), 32'd0);
    check("reset_prdata2", rd2, 32'd0);
    check("reset_pready3", 32'(rdy3), 32'd0);
    check("reset_prdata3", rd3, 32'd0);
    PRESETn = 1'b1;
    mon_en  = 1'b1;

    // Zero wait states: write then read.
    xfer(0, 1'b1, 32'h08, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    idle();
    xfer(0, 1'b0, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    idle();

    // Three wait states, read of a reset word.
    xfer(3, 1'b0, 32'h04, 32'h0, 32'h00000000, 1'b0, 0);
    idle();

    // Back-to-back write/read with no idle cycle.
    xfer(0, 1'b1, 32'h3C, 32'h11111111, 32'h0, 1'b0, 0);
    xfer(0, 1'b0, 32'h3C, 32'h0, 32'h11111111, 1'b0, 0);
    idle();

    // Aborted write on the two-wait slave leaves memory untouched.
    xfer(2, 1'b1, 32'h00, 32'hA5A5A5A5, 32'h0, 1'b0, 1);
    idle();
    xfer(2, 1'b0, 32'h00, 32'h0, 32'h00000000, 1'b0, 0);
    idle();

    // Back-to-back with wait states.
    xfer(3, 1'b1, 32'h20, 32'h0BADF00D, 32'h0, 1'b0, 0);
    xfer(3, 1'b0, 32'h20, 32'h0, 32'h0BADF00D, 1'b0, 0);
    xfer(2, 1'b1, 32'h1C, 32'h5A5A0001, 32'h0, 1'b0, 0);
    xfer(2, 1'b0, 32'h1C, 32'h0, 32'h5A5A0001, 1'b0, 0);
    idle();

`ifdef APB_SLV_PSLVERR_EN
    // Misaligned / out-of-window addresses error out and do not alias.
    xfer(0, 1'b1, 32'h41, 32'h12345678, 32'h00000000, 1'b1, 0);
    idle();
    xfer(0, 1'b0, 32'h00, 32'h0, 32'h00000000, 1'b0, 0);
    xfer(0, 1'b0, 32'h0B, 32'h0, 32'h00000000, 1'b1, 0);
    xfer(0, 1'b0, 32'h08, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    idle();
`else
    // Addresses alias every 64 bytes; low byte bits are ignored.
    xfer(0, 1'b1, 32'h48, 32'hCAFEF00D, 32'h0, 1'b0, 0);
    xfer(0, 1'b0, 32'h08, 32'h0, 32'hCAFEF00D, 1'b0, 0);
    xfer(0, 1'b0, 32'h0B, 32'h0, 32'hCAFEF00D, 1'b0, 0);
    idle();
`endif

    // Reset during the WAIT phase of a write.
    PSEL    = 4'b1000;
    PENABLE = 1'b0;
    PWRITE  = 1'b1;
    PADDR   = 32'h10;
    PWDATA  = 32'h77777777;
    @(posedge CLK);
    #1;
    PENABLE = 1'b1;
    @(posedge CLK);
    #1;
    mon_en  = 1'b0;
    PRESETn = 1'b0;
    @(posedge CLK);
    #1;
    check("midreset_pready3", 32'(rdy3), 32'd0);
    check("midreset_prdata3", rd3, 32'd0);
    PRESETn = 1'b1;
    PSEL    = '0;
    PENABLE = 1'b0;
    mon_en  = 1'b1;
    @(posedge CLK);
    #1;
    xfer(3, 1'b0, 32'h10, 32'h0, 32'h00000000, 1'b0, 0);
    xfer(0, 1'b0, 32'h08, 32'h0, 32'h00000000, 1'b0, 0);
    idle();
    idle();

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
